// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Definitions shared by the IF, ID, EX and control stages of the 5-stage
// pipeline: opcode constants, the link register index, the bubble (NOP)
// encoding and small opcode-classification helpers.
// No ports.

package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // A bubble is an R-type whose destination is r0 with all data zero,
    // which every downstream stage treats as a NOP.
    localparam logic [5:0] BUBBLE_OPCODE = OP_RTYPE;
    localparam logic [4:0] BUBBLE_RD     = REG_ZERO;

    typedef enum logic [1:0] {
        IMM_SIGN,
        IMM_ZERO,
        IMM_UPPER
    } imm_kind_e;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RD,
        DST_RT,
        DST_RA
    } dst_sel_e;

    function automatic imm_kind_e imm_kind(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: imm_kind = IMM_ZERO;
            OP_LUI:                   imm_kind = IMM_UPPER;
            default:                  imm_kind = IMM_SIGN;
        endcase
    endfunction

    function automatic dst_sel_e dst_sel(input logic [5:0] op);
        case (op)
            OP_RTYPE:                         dst_sel = DST_RD;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_LW:                    dst_sel = DST_RT;
            OP_JAL:                           dst_sel = DST_RA;
            default:                          dst_sel = DST_NONE;
        endcase
    endfunction

    // Only these opcodes consume rt as an operand; for the rest rt is a
    // destination or unused and must not trigger a load-use stall.
    function automatic logic rt_is_source(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: rt_is_source = 1'b1;
            default:                         rt_is_source = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// regfile
// 32-entry register file with two combinational read ports, one write
// port committed on the rising clk edge, write-before-read bypass and r0
// hardwired to zero. Synchronous active-high reset clears every entry.
// Ports:
//   clk, reset            clock and synchronous reset
//   we, waddr, wdata      write port (writes to r0 are dropped)
//   raddr_a, rdata_a      read port A
//   raddr_b, rdata_b      read port B

module regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [4:0]            raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [4:0]            raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] regs [32];
    logic                  wr_active;

    assign wr_active = we && (waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[waddr] <= wdata;
        end
    end

    // The write lands at the end of the cycle, so a same-cycle read of the
    // written index is served from wdata directly.
    always_comb begin
        rdata_a = regs[raddr_a];
        if (raddr_a == 5'd0) begin
            rdata_a = '0;
        end else if (wr_active && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = regs[raddr_b];
        if (raddr_b == 5'd0) begin
            rdata_b = '0;
        end else if (wr_active && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// id_stage
// Instruction-decode stage: splits the IF/ID instruction into fields,
// reads operands from the register file (with write-back bypass), forms
// the immediate and destination index, detects load-use hazards and
// replaces the instruction with a bubble on reset, flush or stall.
// All outputs feed the ID/EX register directly and are combinational.
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   instr_in                        instruction from IF/ID
//   wb_we, wb_rd, wb_data           register write-back port
//   ex_mem_read, ex_rd              load-in-EX information for hazards
//   flush                           squash the instruction in ID
//   opcode_out .. imm_out           ID/EX register inputs
//   stall                           hold PC and IF/ID this cycle
//   stall_count                     stall cycles since reset (wrapping)

module id_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr_in,
    input  logic                  wb_we,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rd,
    input  logic                  flush,
    output logic [5:0]            opcode_out,
    output logic [DATA_WIDTH-1:0] rs_data_out,
    output logic [DATA_WIDTH-1:0] rt_data_out,
    output logic [4:0]            rd_out,
    output logic [DATA_WIDTH-1:0] imm_out,
    output logic                  stall,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    logic [5:0]            opcode;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd_field;
    logic [15:0]           imm16;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm_dec;
    logic [4:0]            rd_dec;
    logic                  hazard;
    logic                  bubble;

    assign opcode   = instr_in[31:26];
    assign rs       = instr_in[25:21];
    assign rt       = instr_in[20:16];
    assign rd_field = instr_in[15:11];
    assign imm16    = instr_in[15:0];

    regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rs_data),
        .raddr_b (rt),
        .rdata_b (rt_data)
    );

    always_comb begin
        imm_dec = DATA_WIDTH'(signed'(imm16));
        case (imm_kind(opcode))
            IMM_ZERO:  imm_dec = DATA_WIDTH'(imm16);
            IMM_UPPER: imm_dec = DATA_WIDTH'({imm16, 16'h0000});
            default:   imm_dec = DATA_WIDTH'(signed'(imm16));
        endcase
    end

    always_comb begin
        rd_dec = REG_ZERO;
        case (dst_sel(opcode))
            DST_RD:  rd_dec = rd_field;
            DST_RT:  rd_dec = rt;
            DST_RA:  rd_dec = REG_RA;
            default: rd_dec = REG_ZERO;
        endcase
    end

    // rs is always treated as a source, even for J/JAL/LUI where the field
    // is unused; a rare spurious stall is cheaper than a per-opcode check.
    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == rs) || (rt_is_source(opcode) && (ex_rd == rt)));

    assign bubble = reset || flush || hazard;
    assign stall  = !reset && !flush && hazard;

    always_comb begin
        opcode_out  = opcode;
        rs_data_out = rs_data;
        rt_data_out = rt_data;
        rd_out      = rd_dec;
        imm_out     = imm_dec;
        if (bubble) begin
            opcode_out  = BUBBLE_OPCODE;
            rs_data_out = '0;
            rt_data_out = '0;
            rd_out      = BUBBLE_RD;
            imm_out     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the decode
// rules, register contents and stall counter.

module tb_id_stage;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr_in;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          ex_mem_read;
    logic [4:0]    ex_rd;
    logic          flush;
    logic [5:0]    opcode_out;
    logic [DW-1:0] rs_data_out;
    logic [DW-1:0] rt_data_out;
    logic [4:0]    rd_out;
    logic [DW-1:0] imm_out;
    logic          stall;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    logic [31:0] mcount;

    always #5 clk = ~clk;

    id_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .flush       (flush),
        .opcode_out  (opcode_out),
        .rs_data_out (rs_data_out),
        .rt_data_out (rt_data_out),
        .rd_out      (rd_out),
        .imm_out     (imm_out),
        .stall       (stall),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wb_we && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    task automatic model(output logic [5:0] e_op, output logic [31:0] e_rs,
                         output logic [31:0] e_rt, output logic [4:0] e_rd,
                         output logic [31:0] e_imm, output logic e_st);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rdf;
        logic [15:0] i16;
        logic        rt_src, haz;
        op  = instr_in[31:26];
        rs  = instr_in[25:21];
        rt  = instr_in[20:16];
        rdf = instr_in[15:11];
        i16 = instr_in[15:0];
        rt_src = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        haz = ex_mem_read && ex_rd != 0 && (ex_rd == rs || (rt_src && ex_rd == rt));
        e_op = op;
        e_rs = mread(rs);
        e_rt = mread(rt);
        case (op)
            6'h0C, 6'h0D, 6'h0E: e_imm = {16'h0, i16};
            6'h0F:               e_imm = {i16, 16'h0};
            default:             e_imm = {{16{i16[15]}}, i16};
        endcase
        case (op)
            6'h00:                                     e_rd = rdf;
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
            6'h0F, 6'h23:                              e_rd = rt;
            6'h03:                                     e_rd = 5'd31;
            default:                                   e_rd = 5'd0;
        endcase
        e_st = 1'b0;
        if (reset || flush || haz) begin
            e_op = 0; e_rs = 0; e_rt = 0; e_rd = 0; e_imm = 0;
            e_st = !reset && !flush && haz;
        end
    endtask

    task automatic check_now(input string tag);
        logic [5:0]  e_op;
        logic [31:0] e_rs, e_rt, e_imm;
        logic [4:0]  e_rd;
        logic        e_st;
        model(e_op, e_rs, e_rt, e_rd, e_imm, e_st);
        chk({tag, ".op"},    opcode_out,  e_op);
        chk({tag, ".rs"},    rs_data_out, e_rs);
        chk({tag, ".rt"},    rt_data_out, e_rt);
        chk({tag, ".rd"},    rd_out,      e_rd);
        chk({tag, ".imm"},   imm_out,     e_imm);
        chk({tag, ".stall"}, stall,       e_st);
        chk({tag, ".cnt"},   stall_count, mcount);
    endtask

    // Commit the model state at the edge, then move off the edge.
    task automatic tick();
        logic [5:0]  e_op;
        logic [31:0] e_rs, e_rt, e_imm;
        logic [4:0]  e_rd;
        logic        e_st;
        model(e_op, e_rs, e_rt, e_rd, e_imm, e_st);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            mcount = 32'h0;
        end else begin
            if (wb_we && wb_rd != 0) mregs[wb_rd] = wb_data;
            if (e_st) mcount = mcount + 1;
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; instr_in = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        ex_mem_read = 0; ex_rd = 0; flush = 0;
    endtask

    logic [5:0]  ops [16];
    logic [31:0] cnt_before;
    logic [31:0] r;

    initial begin
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h11, 6'h3F};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mcount = 0;

        // Reset with live-looking inputs: outputs must still be a bubble.
        idle();
        reset = 1; instr_in = 32'h20A6FFFF; wb_we = 1; wb_rd = 5; wb_data = 32'hDEAD0001;
        #3; check_now("reset");
        chk("reset.opcode_lit", opcode_out, 6'h00);
        tick();
        tick();

        // Write r5, then decode ADDI r6,r5,-1.
        idle(); wb_we = 1; wb_rd = 5; wb_data = 32'h12345678;
        #3; check_now("wr_r5"); tick();
        idle(); instr_in = 32'h20A6FFFF;
        #3; check_now("addi");
        chk("addi.rs_lit",  rs_data_out, 32'h12345678);
        chk("addi.rd_lit",  rd_out,      5'd6);
        chk("addi.imm_lit", imm_out,     32'hFFFFFFFF);
        chk("addi.op_lit",  opcode_out,  6'h08);
        tick();

        // Same-cycle bypass into ADD r1,r3,r0.
        idle(); instr_in = 32'h00600820; wb_we = 1; wb_rd = 3; wb_data = 32'hA5A5A5A5;
        #3; check_now("bypass");
        chk("bypass.rs_lit", rs_data_out, 32'hA5A5A5A5);
        chk("bypass.rt_lit", rt_data_out, 32'h0);
        chk("bypass.rd_lit", rd_out,      5'd1);
        tick();

        // r0 stays zero.
        idle(); wb_we = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF; instr_in = 32'h00000820;
        #3; check_now("wr_r0"); chk("wr_r0.bypass_lit", rs_data_out, 32'h0); tick();
        idle(); instr_in = 32'h00000820;
        #3; check_now("rd_r0"); chk("rd_r0.lit", rs_data_out, 32'h0); tick();

        idle(); instr_in = 32'h34028000;
        #3; check_now("ori"); chk("ori.imm_lit", imm_out, 32'h00008000); tick();
        idle(); instr_in = 32'h3C028000;
        #3; check_now("lui"); chk("lui.imm_lit", imm_out, 32'h80000000); tick();

        // Load-use on rt of SW, then ADDI with r4 as destination.
        idle(); instr_in = 32'hACE40000; ex_mem_read = 1; ex_rd = 4;
        cnt_before = stall_count;
        #3; check_now("sw_haz"); chk("sw_haz.stall_lit", stall, 1'b1); tick();
        idle();
        #3; chk("sw_haz.cnt_inc", stall_count, cnt_before + 1); check_now("after_sw"); tick();
        idle(); instr_in = 32'h20E40001; ex_mem_read = 1; ex_rd = 4;
        #3; check_now("addi_nohaz"); chk("addi_nohaz.stall_lit", stall, 1'b0); tick();

        // Flush overrides hazard; ex_rd=0 never stalls.
        idle(); instr_in = 32'hACE40000; ex_mem_read = 1; ex_rd = 4; flush = 1;
        cnt_before = stall_count;
        #3; check_now("flush_haz"); chk("flush_haz.stall_lit", stall, 1'b0); tick();
        idle();
        #3; chk("flush_haz.cnt_same", stall_count, cnt_before); tick();
        idle(); instr_in = 32'h00000820; ex_mem_read = 1; ex_rd = 0;
        #3; check_now("exrd0"); chk("exrd0.stall_lit", stall, 1'b0); tick();

        // Three stall cycles, then reset mid-stall.
        for (int i = 0; i < 3; i++) begin
            idle(); instr_in = 32'hACE40000; ex_mem_read = 1; ex_rd = 4;
            #3; check_now("stall3"); tick();
        end
        idle(); instr_in = 32'hACE40000; ex_mem_read = 1; ex_rd = 4; reset = 1;
        #3; check_now("rst_mid"); chk("rst_mid.stall_lit", stall, 1'b0); tick();
        idle(); instr_in = 32'h00A63820;  // ADD r7,r5,r6
        #3; check_now("post_rst");
        chk("post_rst.cnt_lit", stall_count, 32'h0);
        chk("post_rst.rs_lit",  rs_data_out, 32'h0);
        tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            idle();
            r = $urandom;
            instr_in = $urandom;
            if (r[1:0] != 2'b00) instr_in[31:26] = ops[r[5:2]];
            reset = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 7) == 0);
            wb_we = r[6] | r[7];
            wb_rd = ($urandom_range(0, 3) == 0) ? instr_in[25:21] : 5'($urandom_range(0, 31));
            wb_data = $urandom;
            ex_mem_read = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       ex_rd = instr_in[25:21];
                1:       ex_rd = instr_in[20:16];
                default: ex_rd = 5'($urandom_range(0, 31));
            endcase
            #3; check_now("rand"); tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage pipeline: sits between the IF/ID register and the ID/EX register and produces exactly the ID/EX register's inputs (opcode, rs data, rt data, destination register, immediate). Owns the 32-entry register file with its write-back port, write-before-read bypass, load-use hazard detection with stall/bubble generation, and a stall counter.

## Interface
Parameters:
- DATA_WIDTH, 32, register and datapath width.
- CNT_WIDTH, 32, width of the stall counter.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- instr_in  input  32  instruction from IF/ID.
- wb_we  input  1  write-back enable.
- wb_rd  input  5  write-back register index.
- wb_data  input  DATA_WIDTH  write-back data.
- ex_mem_read  input  1  instruction currently in EX is a load.
- ex_rd  input  5  destination register of the instruction in EX.
- flush  input  1  squash the instruction in ID (taken branch or jump).
- opcode_out  output  6  to ID/EX opcode_in.
- rs_data_out  output  DATA_WIDTH  to ID/EX rs_data_in.
- rt_data_out  output  DATA_WIDTH  to ID/EX rt_data_in.
- rd_out  output  5  to ID/EX rd_in; 0 means no write.
- imm_out  output  DATA_WIDTH  to ID/EX imm_in.
- stall  output  1  hold the PC and IF/ID this cycle.
- stall_count  output  CNT_WIDTH  number of stall cycles since reset.

## Operation
- Field extraction:
  - opcode = instr[31:26]
  - rs = [25:21]
  - rt = [20:16]
  - rd = [15:11]
- Immediate:
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: zero-extend instr[15:0].
  - LUI 0x0F: {instr[15:0], 16'b0}.
  - All other opcodes, R-type included: sign-extend instr[15:0]. For R-type, funct = imm_out[5:0] and shamt = imm_out[10:6].
- Destination (rd_out):
  - R-type 0x00: rd.
  - ADDI 0x08, ADDIU 0x09, SLTI 0x0A, ANDI, ORI, XORI, LUI, LW 0x23: rt.
  - JAL 0x03: 31.
  - SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, and any undefined opcode: 0.
- rt is a source operand only for R-type, SW, BEQ, BNE. rs is always treated as a source.
- Register file: 32 × DATA_WIDTH.
  - Written on the clk edge when wb_we=1 and wb_rd≠0.
  - Register 0 always reads 0; writes to it are ignored.
- Bypass: if wb_we=1, wb_rd≠0 and wb_rd equals the read index, the read port returns wb_data in the same cycle (write-before-read).
- Load-use hazard: asserted when ex_mem_read=1, ex_rd≠0, and either ex_rd==rs or (ex_rd==rt and rt is a source).
- Bubble: all outputs (opcode, data, rd, imm) = 0. This is an R-type writing r0, i.e. a NOP.
- Priority, highest first:
  1. reset: bubble, stall=0.
  2. flush: bubble, stall=0. Flush wins over a simultaneous hazard.
  3. hazard: bubble, stall=1.
  4. Otherwise the decoded outputs, stall=0.
- stall_count increments by 1 at each clk edge where stall=1. Wraps modulo 2^CNT_WIDTH.

## Timing
- Decode outputs, stall and the bypass path are combinational from the inputs. Latency to the ID/EX register is zero cycles; the ID/EX register captures them on the next edge.
- A register-file write takes effect at the clk edge. The same cycle's read already sees it through the bypass.
- A load-use stall lasts exactly one cycle per hazard: on the next cycle EX holds the bubble, so ex_mem_read=0.
- Reset value of every output is 0 while reset is high.
- On reset: all 32 registers and stall_count clear to 0 at the first clk edge with reset high. Reset asserted mid-stall clears the counter and drops stall in the same cycle.
- wb_we during reset is ignored (reset wins).

## Structure
- Shared package (pipeline_pkg): opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW), the REG_RA=31 constant, and the bubble encoding. The package is shared with the IF, EX and control stages.
- Sub-module: regfile (two combinational read ports with bypass, one synchronous write port, r0 hardwired to zero).
- Decode and hazard logic stay in id_stage.

## Test plan
- Reset, then write r5=0x12345678 via WB; decode ADDI r6,r5,-1 (0x20A6FFFF) -> rs_data_out=0x12345678, rd_out=6, imm_out=0xFFFFFFFF, opcode_out=0x08.
- Same-cycle bypass: wb_we=1, wb_rd=3, wb_data=0xA5A5A5A5 while decoding R-type ADD r1,r3,r0 -> rs_data_out=0xA5A5A5A5, rt_data_out=0, rd_out=1.
- Write r0=0xFFFFFFFF, then read r0 -> 0. ORI r2,r0,0x8000 -> imm_out=0x00008000. LUI r2,0x8000 -> imm_out=0x80000000.
- ex_mem_read=1, ex_rd=4, decode SW r4,0(r7) -> stall=1, all outputs 0, stall_count +1. Repeat with ADDI r4,r7,1 (rt is the destination) -> stall=0.
- Hazard condition together with flush=1 -> stall=0, bubble, stall_count unchanged. Hazard with ex_rd=0 -> no stall.
- Assert reset after 3 stall cycles -> stall_count=0, stall=0, registers read 0 on the following cycle.
